uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. It accepts one byte at a time from a valid/ready requester and drives the transmitter's `data_rdy_in`/`tx_data_in`. It then holds ownership until the transmitter reports `tx_done_out`, or until a watchdog expires. It sits between the application-side producers (status reporter, debug console, command responder) and the single `uart_tx` instance.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DATA_BITS`, 8: byte width; must match `uart_tx`.
- `TIMEOUT_CYCLES`, 65535: maximum `sysclk_in` cycles from grant to `tx_done_in` before abort; must be ≥ 16.

Ports:
- `sysclk_in`  in  1  system clock; all logic on rising edge.
- `nrst_in`  in  1  asynchronous, active-low reset.
- `req_valid_in`  in  NUM_REQ  requester i has a byte pending.
- `req_data_in`  in  NUM_REQ*DATA_BITS  requester i's byte, at `[i*DATA_BITS +: DATA_BITS]`.
- `req_ready_out`  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i consumed.
- `grant_id_out`  out  $clog2(NUM_REQ)  index of current/last owner.
- `tx_data_rdy_out`  out  1  to `uart_tx.data_rdy_in`.
- `tx_data_out`  out  DATA_BITS  to `uart_tx.tx_data_in`; stable while `tx_data_rdy_out`=1.
- `tx_busy_in`  in  1  from `uart_tx.tx_busy_out`.
- `tx_done_in`  in  1  from `uart_tx.tx_done_out`.
- `busy_out`  out  1  arbiter not in IDLE.
- `timeout_out`  out  1  one-cycle pulse on watchdog abort.

## Operation

- **States:** IDLE, LOAD, WAIT_DONE. Unreachable encodings go to IDLE.
- **IDLE:**
  - Grant only when some `req_valid_in` bit is 1 and `tx_busy_in`=0.
  - Winner is the first valid index searching upward, with wrap, from `(last_grant+1) mod NUM_REQ`.
  - On grant: latch the winner's byte into `tx_data_out`, set `grant_id_out`, pulse `req_ready_out[winner]`, clear the watchdog, go to LOAD.
- **LOAD:**
  - `tx_data_rdy_out`=1 until `tx_busy_in` is sampled 1.
  - Then deassert `tx_data_rdy_out` and go to WAIT_DONE.
- **WAIT_DONE:**
  - On `tx_done_in`=1: `last_grant <= grant_id_out`, go to IDLE.
- **Watchdog:**
  - Increments every cycle in LOAD and WAIT_DONE.
  - On reaching `TIMEOUT_CYCLES-1`: pulse `timeout_out`, deassert `tx_data_rdy_out`, `last_grant <= grant_id_out`, go to IDLE.
  - The byte is dropped, not retried.
- **Counter width:** watchdog width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.
- **Simultaneous events:** if `tx_done_in` and watchdog expiry occur in the same cycle, done wins and there is no `timeout_out` pulse.
- **Requester contract:**
  - A requester may drop `req_valid_in` before it is granted; nothing is latched for it.
  - After `req_ready_out`, the requester presents its next byte or deasserts valid.
- **Reset (async, any state):**
  - state=IDLE, `tx_data_rdy_out`=0, `tx_data_out`=0, `req_ready_out`=0, `grant_id_out`=0, `busy_out`=0, `timeout_out`=0, watchdog=0.
  - `last_grant`=NUM_REQ-1, so requester 0 has first priority.
  - A frame in flight inside `uart_tx` is not tracked; after reset the arbiter waits for `tx_busy_in`=0.

## Timing

- All outputs are registered.
- **Grant latency:** a valid request sampled in IDLE at edge N gives `req_ready_out` and `tx_data_rdy_out` high after edge N; `busy_out`=1 in the same cycle.
- `req_ready_out` is exactly one cycle wide. `tx_data_rdy_out` lasts ≥1 cycle, ending the cycle after `tx_busy_in` is seen high.
- **Back-to-back transfers:** after done, the next grant needs `tx_busy_in`=0.
  - With `uart_tx` this is ≥2 cycles after `tx_done_in`.
  - There is no bubble beyond what the transmitter imposes.
- **Fairness:** with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0. Maximum wait is (NUM_REQ-1) frames.

## Structure

- Shared header `uart_defs.vh` holds:
  - arbiter state encodings `ARB_IDLE_s`=2'b00, `ARB_LOAD_s`=2'b01, `ARB_WAIT_DONE_s`=2'b10;
  - the default `DATA_BITS`.
- Sub-module `rr_picker`: combinational priority search over `req_valid_in` from a start pointer.
  - Outputs: `any_valid`, winner index.
  - Reusable by a future RX-side dispatcher.
- Top level holds the FSM, data latch, watchdog and `last_grant` register.

## Test plan

- **Reset:** assert `nrst_in` mid-WAIT_DONE -> all outputs 0 asynchronously. After release with `req_valid_in`=4'b1111, the first grant is `grant_id_out`=0.
- **Single requester:** requester 2 sends 0xA5 against the real `uart_tx` (OVERSAMPLING=8) -> exactly one `req_ready_out`=4'b0100 pulse, serial line carries 0xA5 LSB-first, `busy_out` falls after `tx_done_in`.
- **Round-robin:** all four valid, bytes 0x10/0x21/0x32/0x43 -> serial order 0x10,0x21,0x32,0x43,0x10. Starting with `last_grant`=1 and only requesters 0 and 3 valid -> requester 3 first.
- **Watchdog:** model `tx_done_in` stuck 0 with TIMEOUT_CYCLES=32 -> `timeout_out` pulses 32 cycles after grant, state IDLE, next requester granted.
- **Done/timeout collision:** `tx_done_in` in the expiry cycle -> no `timeout_out`, normal return to IDLE.
- **Busy gating:** `tx_busy_in` held 1 in IDLE with a request pending -> no grant until it drops. Grant follows on the next edge.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encodings and the
// default byte width, which has to agree with the uart_tx instance.
package uart_tx_arbiter_pkg;

   localparam int DEFAULT_DATA_BITS = 8;

   typedef enum logic [1:0] {
      ARB_IDLE_s      = 2'b00,
      ARB_LOAD_s      = 2'b01,
      ARB_WAIT_DONE_s = 2'b10
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of valid, scanning upward
// with wrap-around from index start. Also meant for a later RX-side dispatcher.
module rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] start,
   output logic             any_valid,
   output logic [IDX_W-1:0] winner
);

   int idx;

   // Scan from the far end back to start so the nearest candidate is written last.
   always_comb begin
      any_valid = |valid;
      winner    = '0;
      idx       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= N) idx = idx - N;
         if (valid[idx]) winner = IDX_W'(idx);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// with a watchdog that drops the byte if the transmitter never reports done.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_BITS      = DEFAULT_DATA_BITS,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                         sysclk_in,
   input  logic                         nrst_in,
   input  logic [NUM_REQ-1:0]           req_valid_in,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data_in,
   output logic [NUM_REQ-1:0]           req_ready_out,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id_out,
   output logic                         tx_data_rdy_out,
   output logic [DATA_BITS-1:0]         tx_data_out,
   input  logic                         tx_busy_in,
   input  logic                         tx_done_in,
   output logic                         busy_out,
   output logic                         timeout_out,
   output logic [1:0]                   arb_state_out
);

   // Handshake: a requester holds req_valid_in with a stable byte until it sees
   // its req_ready_out pulse; the byte is consumed on the edge that raises it.

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_MAX   = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   arb_state_t           state;
   logic [WD_W-1:0]      wd_cnt;
   logic [IDX_W-1:0]     last_grant;
   logic [IDX_W-1:0]     start_idx;
   logic [IDX_W-1:0]     winner;
   logic                 any_valid;
   logic [DATA_BITS-1:0] win_data;

   assign start_idx     = (last_grant == IDX_LAST) ? '0 : last_grant + 1'b1;
   assign arb_state_out = state;

   rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .valid     (req_valid_in),
      .start     (start_idx),
      .any_valid (any_valid),
      .winner    (winner)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) win_data = req_data_in[i*DATA_BITS +: DATA_BITS];
      end
   end

   always_ff @(posedge sysclk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state           <= ARB_IDLE_s;
         tx_data_rdy_out <= 1'b0;
         tx_data_out     <= '0;
         req_ready_out   <= '0;
         grant_id_out    <= '0;
         busy_out        <= 1'b0;
         timeout_out     <= 1'b0;
         wd_cnt          <= '0;
         last_grant      <= IDX_LAST;
      end else begin
         req_ready_out <= '0;
         timeout_out   <= 1'b0;
         if (state != ARB_IDLE_s && wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;

         case (state)
            ARB_IDLE_s: begin
               if (any_valid && !tx_busy_in) begin
                  state           <= ARB_LOAD_s;
                  tx_data_out     <= win_data;
                  grant_id_out    <= winner;
                  req_ready_out   <= NUM_REQ'(1) << winner;
                  tx_data_rdy_out <= 1'b1;
                  busy_out        <= 1'b1;
                  wd_cnt          <= '0;
               end
            end
            ARB_LOAD_s: begin
               if (wd_cnt >= WD_LAST) begin
                  state           <= ARB_IDLE_s;
                  tx_data_rdy_out <= 1'b0;
                  busy_out        <= 1'b0;
                  timeout_out     <= 1'b1;
                  last_grant      <= grant_id_out;
               end else if (tx_busy_in) begin
                  state           <= ARB_WAIT_DONE_s;
                  tx_data_rdy_out <= 1'b0;
               end
            end
            ARB_WAIT_DONE_s: begin
               // A done arriving in the expiry cycle still counts as a clean finish.
               if (tx_done_in) begin
                  state      <= ARB_IDLE_s;
                  busy_out   <= 1'b0;
                  last_grant <= grant_id_out;
               end else if (wd_cnt >= WD_LAST) begin
                  state       <= ARB_IDLE_s;
                  busy_out    <= 1'b0;
                  timeout_out <= 1'b1;
                  last_grant  <= grant_id_out;
               end
            end
            default: begin
               state           <= ARB_IDLE_s;
               tx_data_rdy_out <= 1'b0;
               busy_out        <= 1'b0;
            end
         endcase
      end
   end

endmodule
